// File: rtl/adder4a.sv
// Registered 4-bit two-level carry-lookahead adder with group generate/propagate outputs.
// Optional signed-overflow output ovf is built when ADDER4A_OVF_EN is defined.
module adder4a (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] s,
  output logic       c4,
  output logic       gg,
  output logic       gp
`ifdef ADDER4A_OVF_EN
  ,
  output logic       ovf
`endif
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] s_d;
  logic       gg_d;
  logic       gp_d;

  logic [3:0] s_q;
  logic       c4_q;
  logic       gg_q;
  logic       gp_q;

  always_comb begin
    g = a & b;
    p = a ^ b;
    // Flattened lookahead; every carry is two gate levels from g/p, carry-in is 0.
    c[0] = 1'b0;
    c[1] = g[0];
    c[2] = g[1] | (p[1] & g[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    s_d  = p ^ c[3:0];
    gg_d = c[4];
    gp_d = &p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= 4'b0000;
      c4_q <= 1'b0;
      gg_q <= 1'b0;
      gp_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      c4_q <= c[4];
      gg_q <= gg_d;
      gp_q <= gp_d;
    end
  end

  assign s  = s_q;
  assign c4 = c4_q;
  assign gg = gg_q;
  assign gp = gp_q;

`ifdef ADDER4A_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= c[4] ^ c[3];
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder4a.sv
// Directed and exhaustive self-checking bench for adder4a.
// Build with ADDER4A_OVF_EN defined to also cover the ovf output.
module tb_adder4a;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] s;
  logic       c4;
  logic       gg;
  logic       gp;
`ifdef ADDER4A_OVF_EN
  logic       ovf;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  adder4a u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .s     (s),
    .c4    (c4),
    .gg    (gg),
    .gp    (gp)
`ifdef ADDER4A_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_s, input logic e_c4,
                           input logic e_gg, input logic e_gp, input logic e_ovf);
    check({tag, ".s"},  {4'h0, s},  {4'h0, e_s});
    check({tag, ".c4"}, {7'h0, c4}, {7'h0, e_c4});
    check({tag, ".gg"}, {7'h0, gg}, {7'h0, e_gg});
    check({tag, ".gp"}, {7'h0, gp}, {7'h0, e_gp});
`ifdef ADDER4A_OVF_EN
    check({tag, ".ovf"}, {7'h0, ovf}, {7'h0, e_ovf});
`else
    if (e_ovf) begin
    end
`endif
  endtask

  initial begin
    logic [4:0] sum;
    logic       e_ovf;
    n_checks = 0;
    n_errors = 0;
    a     = 4'b0000;
    b     = 4'b0000;
    rst_n = 1'b0;
    #12;
    check_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // p = 1101 here, so group propagate is 0.
    a = 4'b1000; b = 4'b0101;
    step();
    check_out("v1000_0101", 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);

    a = 4'b0110; b = 4'b0001;
    #2;
    check_out("hold_before_edge", 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("v0110_0001", 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("hold_same_inputs", 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);

    a = 4'b1111; b = 4'b0001;
    step();
    check_out("v1111_0001", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

    a = 4'b1010; b = 4'b0101;
    step();
    check_out("v1010_0101_gp", 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);

    a = 4'b0111; b = 4'b0001;
    step();
    check_out("v0111_0001", 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);

    a = 4'b1000; b = 4'b1000;
    step();
    check_out("v1000_1000", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);

    a = 4'b1111; b = 4'b1111;
    step();
    check_out("v1111_1111", 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges, held across edges, then released.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_out("reset_held", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    check_out("release_no_replay", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("after_release", 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = i[3:0];
        b = j[3:0];
        sum   = {1'b0, a} + {1'b0, b};
        e_ovf = (a[3] == b[3]) && (sum[3] != a[3]);
        step();
        check_out($sformatf("sweep_%0h_%0h", i, j), sum[3:0], sum[4], sum[4],
                  ((a ^ b) == 4'hf), e_ovf);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
